// File: rtl/rat_map.sv
`default_nettype none
// ============================================================================
// Module  : rat_map
// Brief   : Four-wide register alias table with per-branch snapshot emission,
//           checkpoint slot allocation and rollback restore.
//           Optional macro RAT_R0_ZERO_EN pins architectural r0 to tag 0.
// Revision: 1.0 - initial release
// ============================================================================
module rat_map #(
  parameter int NREG = 32,
  parameter int TAGW = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ren_valid_a, ren_valid_b, ren_valid_c, ren_valid_d,
  input  logic [$clog2(NREG)-1:0]   ren_src1_a, ren_src1_b, ren_src1_c, ren_src1_d,
  input  logic [$clog2(NREG)-1:0]   ren_src2_a, ren_src2_b, ren_src2_c, ren_src2_d,
  input  logic [$clog2(NREG)-1:0]   ren_dst_a, ren_dst_b, ren_dst_c, ren_dst_d,
  input  logic                      ren_dst_we_a, ren_dst_we_b, ren_dst_we_c, ren_dst_we_d,
  input  logic [TAGW-1:0]           ren_new_tag_a, ren_new_tag_b, ren_new_tag_c, ren_new_tag_d,
  input  logic                      ren_branch_a, ren_branch_b, ren_branch_c, ren_branch_d,
  output logic                      ren_stall,
  output logic                      out_valid_a, out_valid_b, out_valid_c, out_valid_d,
  output logic [TAGW-1:0]           out_src1_tag_a, out_src1_tag_b, out_src1_tag_c, out_src1_tag_d,
  output logic [TAGW-1:0]           out_src2_tag_a, out_src2_tag_b, out_src2_tag_c, out_src2_tag_d,
  output logic [TAGW-1:0]           out_old_tag_a, out_old_tag_b, out_old_tag_c, out_old_tag_d,
  output logic [2:0]                out_shot_id_a, out_shot_id_b, out_shot_id_c, out_shot_id_d,
  input  logic [31:0]               rat_shot_air,
  output logic [NREG*TAGW-1:0]      rat_shot_in_a, rat_shot_in_b, rat_shot_in_c, rat_shot_in_d,
  output logic                      rat_start_a, rat_start_b, rat_start_c, rat_start_d,
  input  logic [NREG*TAGW-1:0]      rob_kill_adderss,
  input  logic                      rob_kill_start
);

  localparam int NL = 4;
  localparam int AW = $clog2(NREG);
  localparam int SW = NREG * TAGW;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_RESTORE = 1'b1} state_t;
  state_t r_state, w_state_nxt;

  logic [NREG-1:0][TAGW-1:0]        r_map, w_kill_map;
  logic [NL:0][NREG-1:0][TAGW-1:0]  w_stage;
  logic [NL-1:0]                    w_valid, w_we, w_br, w_wr;
  logic [NL-1:0][AW-1:0]            w_src1, w_src2, w_dst;
  logic [NL-1:0][TAGW-1:0]          w_new, w_old;
  logic [NL-1:0][2:0]               w_shot_id;
  logic [NL-1:0][SW-1:0]            w_snap;
  logic [3:0]                       w_free;
  logic                             w_short, w_accept, w_unused;

  logic [NL-1:0]                    r_out_valid, r_start;
  logic [NL-1:0][TAGW-1:0]          r_src1_tag, r_src2_tag, r_old_tag;
  logic [NL-1:0][2:0]               r_shot_id;
  logic [NL-1:0][SW-1:0]            r_snap;

  assign w_valid = {ren_valid_d, ren_valid_c, ren_valid_b, ren_valid_a};
  assign w_we    = {ren_dst_we_d, ren_dst_we_c, ren_dst_we_b, ren_dst_we_a};
  assign w_br    = {ren_branch_d, ren_branch_c, ren_branch_b, ren_branch_a};
  assign w_src1  = {ren_src1_d, ren_src1_c, ren_src1_b, ren_src1_a};
  assign w_src2  = {ren_src2_d, ren_src2_c, ren_src2_b, ren_src2_a};
  assign w_dst   = {ren_dst_d, ren_dst_c, ren_dst_b, ren_dst_a};
  assign w_new   = {ren_new_tag_d, ren_new_tag_c, ren_new_tag_b, ren_new_tag_a};
  assign w_unused = ^{rat_shot_air[30:27], rat_shot_air[22:19], rat_shot_air[14:11], rat_shot_air[6:3]};

  for (genvar j = 0; j < 4; j++) begin : g_free
    assign w_free[j] = rat_shot_air[8*j+7];
  end

  for (genvar k = 0; k < NL; k++) begin : g_lane
`ifdef RAT_R0_ZERO_EN
    assign w_wr[k]  = w_valid[k] & w_we[k] & (w_dst[k] != '0);
    assign w_old[k] = (w_dst[k] == '0) ? '0 : w_stage[k][w_dst[k]];
`else
    assign w_wr[k]  = w_valid[k] & w_we[k];
    assign w_old[k] = w_stage[k][w_dst[k]];
`endif
  end

  // w_stage[k] is the map as seen by lane k: earlier lanes of the group applied.
  always_comb begin : p_stage
    logic [NREG-1:0][TAGW-1:0] v_map;
    v_map      = r_map;
    w_stage[0] = v_map;
    for (int k = 0; k < NL; k++) begin
      if (w_wr[k]) v_map[w_dst[k]] = w_new[k];
      w_stage[k+1] = v_map;
    end
  end

  always_comb begin : p_snap
    w_kill_map = rob_kill_adderss;
    for (int k = 0; k < NL; k++) w_snap[k] = w_stage[k+1];
`ifdef RAT_R0_ZERO_EN
    w_kill_map[0] = '0;
    for (int k = 0; k < NL; k++) w_snap[k][TAGW-1:0] = '0;
`endif
  end

  // Branch lanes in order a..d claim the lowest unclaimed valid free field.
  always_comb begin : p_alloc
    logic [3:0] v_used;
    logic       v_found;
    v_used    = '0;
    v_found   = 1'b0;
    w_shot_id = '0;
    w_short   = 1'b0;
    for (int k = 0; k < NL; k++) begin
      if (w_valid[k] && w_br[k]) begin
        v_found = 1'b0;
        for (int j = 0; j < 4; j++) begin
          if (!v_found && w_free[j] && !v_used[j]) begin
            v_found      = 1'b1;
            v_used[j]    = 1'b1;
            w_shot_id[k] = rat_shot_air[8*j +: 3];
          end
        end
        if (!v_found) w_short = 1'b1;
      end
    end
  end

  assign ren_stall = (r_state != ST_RUN) | rob_kill_start | w_short;
  assign w_accept  = ~ren_stall;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:     if (rob_kill_start) w_state_nxt = ST_RESTORE;
      ST_RESTORE: w_state_nxt = rob_kill_start ? ST_RESTORE : ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_map[i] <= TAGW'(i);
      r_out_valid <= '0;
      r_start     <= '0;
      r_src1_tag  <= '0;
      r_src2_tag  <= '0;
      r_old_tag   <= '0;
      r_shot_id   <= '0;
      r_snap      <= '0;
    end else begin
      r_out_valid <= w_accept ? w_valid : '0;
      r_start     <= w_accept ? (w_valid & w_br) : '0;
      if (rob_kill_start)  r_map <= w_kill_map;
      else if (w_accept)   r_map <= w_stage[NL];
      if (w_accept) begin
        for (int k = 0; k < NL; k++) begin
          r_src1_tag[k] <= w_stage[k][w_src1[k]];
          r_src2_tag[k] <= w_stage[k][w_src2[k]];
          r_old_tag[k]  <= w_old[k];
          r_shot_id[k]  <= w_shot_id[k];
          r_snap[k]     <= w_snap[k];
        end
      end
    end
  end

  assign {out_valid_d, out_valid_c, out_valid_b, out_valid_a} = r_out_valid;
  assign {rat_start_d, rat_start_c, rat_start_b, rat_start_a} = r_start;
  assign {out_src1_tag_d, out_src1_tag_c, out_src1_tag_b, out_src1_tag_a} = r_src1_tag;
  assign {out_src2_tag_d, out_src2_tag_c, out_src2_tag_b, out_src2_tag_a} = r_src2_tag;
  assign {out_old_tag_d, out_old_tag_c, out_old_tag_b, out_old_tag_a} = r_old_tag;
  assign {out_shot_id_d, out_shot_id_c, out_shot_id_b, out_shot_id_a} = r_shot_id;
  assign {rat_shot_in_d, rat_shot_in_c, rat_shot_in_b, rat_shot_in_a} = r_snap;

endmodule
`default_nettype wire

// File: tb/tb_rat_map.sv
`default_nettype none
// Directed self-checking bench for rat_map: forwarding, slots, snapshots,
// stall, rollback and reset; r0 expectations follow RAT_R0_ZERO_EN.
module tb_rat_map;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic ren_valid_a, ren_valid_b, ren_valid_c, ren_valid_d;
  logic [4:0] ren_src1_a, ren_src1_b, ren_src1_c, ren_src1_d;
  logic [4:0] ren_src2_a, ren_src2_b, ren_src2_c, ren_src2_d;
  logic [4:0] ren_dst_a, ren_dst_b, ren_dst_c, ren_dst_d;
  logic ren_dst_we_a, ren_dst_we_b, ren_dst_we_c, ren_dst_we_d;
  logic [7:0] ren_new_tag_a, ren_new_tag_b, ren_new_tag_c, ren_new_tag_d;
  logic ren_branch_a, ren_branch_b, ren_branch_c, ren_branch_d;
  logic ren_stall;
  logic out_valid_a, out_valid_b, out_valid_c, out_valid_d;
  logic [7:0] out_src1_tag_a, out_src1_tag_b, out_src1_tag_c, out_src1_tag_d;
  logic [7:0] out_src2_tag_a, out_src2_tag_b, out_src2_tag_c, out_src2_tag_d;
  logic [7:0] out_old_tag_a, out_old_tag_b, out_old_tag_c, out_old_tag_d;
  logic [2:0] out_shot_id_a, out_shot_id_b, out_shot_id_c, out_shot_id_d;
  logic [31:0] rat_shot_air;
  logic [255:0] rat_shot_in_a, rat_shot_in_b, rat_shot_in_c, rat_shot_in_d;
  logic rat_start_a, rat_start_b, rat_start_c, rat_start_d;
  logic [255:0] rob_kill_adderss;
  logic rob_kill_start;

  int checks = 0;
  int errors = 0;
  logic [7:0] m [32];
  logic [255:0] exp_b, exp_d;

  rat_map dut (
    .clk(clk), .reset(reset),
    .ren_valid_a(ren_valid_a), .ren_valid_b(ren_valid_b), .ren_valid_c(ren_valid_c), .ren_valid_d(ren_valid_d),
    .ren_src1_a(ren_src1_a), .ren_src1_b(ren_src1_b), .ren_src1_c(ren_src1_c), .ren_src1_d(ren_src1_d),
    .ren_src2_a(ren_src2_a), .ren_src2_b(ren_src2_b), .ren_src2_c(ren_src2_c), .ren_src2_d(ren_src2_d),
    .ren_dst_a(ren_dst_a), .ren_dst_b(ren_dst_b), .ren_dst_c(ren_dst_c), .ren_dst_d(ren_dst_d),
    .ren_dst_we_a(ren_dst_we_a), .ren_dst_we_b(ren_dst_we_b), .ren_dst_we_c(ren_dst_we_c), .ren_dst_we_d(ren_dst_we_d),
    .ren_new_tag_a(ren_new_tag_a), .ren_new_tag_b(ren_new_tag_b), .ren_new_tag_c(ren_new_tag_c), .ren_new_tag_d(ren_new_tag_d),
    .ren_branch_a(ren_branch_a), .ren_branch_b(ren_branch_b), .ren_branch_c(ren_branch_c), .ren_branch_d(ren_branch_d),
    .ren_stall(ren_stall),
    .out_valid_a(out_valid_a), .out_valid_b(out_valid_b), .out_valid_c(out_valid_c), .out_valid_d(out_valid_d),
    .out_src1_tag_a(out_src1_tag_a), .out_src1_tag_b(out_src1_tag_b), .out_src1_tag_c(out_src1_tag_c), .out_src1_tag_d(out_src1_tag_d),
    .out_src2_tag_a(out_src2_tag_a), .out_src2_tag_b(out_src2_tag_b), .out_src2_tag_c(out_src2_tag_c), .out_src2_tag_d(out_src2_tag_d),
    .out_old_tag_a(out_old_tag_a), .out_old_tag_b(out_old_tag_b), .out_old_tag_c(out_old_tag_c), .out_old_tag_d(out_old_tag_d),
    .out_shot_id_a(out_shot_id_a), .out_shot_id_b(out_shot_id_b), .out_shot_id_c(out_shot_id_c), .out_shot_id_d(out_shot_id_d),
    .rat_shot_air(rat_shot_air),
    .rat_shot_in_a(rat_shot_in_a), .rat_shot_in_b(rat_shot_in_b), .rat_shot_in_c(rat_shot_in_c), .rat_shot_in_d(rat_shot_in_d),
    .rat_start_a(rat_start_a), .rat_start_b(rat_start_b), .rat_start_c(rat_start_c), .rat_start_d(rat_start_d),
    .rob_kill_adderss(rob_kill_adderss), .rob_kill_start(rob_kill_start)
  );

  function automatic logic [255:0] pack_map();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[8*i +: 8] = m[i];
    return v;
  endfunction

  task automatic idle();
    {ren_valid_a, ren_valid_b, ren_valid_c, ren_valid_d} = '0;
    {ren_src1_a, ren_src1_b, ren_src1_c, ren_src1_d} = '0;
    {ren_src2_a, ren_src2_b, ren_src2_c, ren_src2_d} = '0;
    {ren_dst_a, ren_dst_b, ren_dst_c, ren_dst_d} = '0;
    {ren_dst_we_a, ren_dst_we_b, ren_dst_we_c, ren_dst_we_d} = '0;
    {ren_new_tag_a, ren_new_tag_b, ren_new_tag_c, ren_new_tag_d} = '0;
    {ren_branch_a, ren_branch_b, ren_branch_c, ren_branch_d} = '0;
    rob_kill_start = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0; rat_shot_air = '0; rob_kill_adderss = '0;
    for (int i = 0; i < 32; i++) m[i] = 8'(i);
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({out_valid_d, out_valid_c, out_valid_b, out_valid_a} !== 4'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", {out_valid_d, out_valid_c, out_valid_b, out_valid_a}); end
    checks++; if ({rat_start_d, rat_start_c, rat_start_b, rat_start_a} !== 4'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", {rat_start_d, rat_start_c, rat_start_b, rat_start_a}); end
    checks++; if (rat_shot_in_a !== '0) begin errors++; $display("FAIL reset_snap: got %h expected 0", rat_shot_in_a); end
    @(negedge clk);
    reset = 1'b1;
    ren_valid_a = 1; ren_src1_a = 5; ren_src2_a = 31; ren_branch_a = 1;
    rat_shot_air = 32'h0000_8700;
    #1;
    checks++; if (ren_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", ren_stall); end
    @(posedge clk); #1;
    checks++; if (out_valid_a !== 1'b1 || out_valid_b !== 1'b0) begin errors++; $display("FAIL first_valid: got a=%b b=%b expected a=1 b=0", out_valid_a, out_valid_b); end
    checks++; if (out_src1_tag_a !== 8'd5) begin errors++; $display("FAIL first_src1: got %h expected 05", out_src1_tag_a); end
    checks++; if (out_src2_tag_a !== 8'd31) begin errors++; $display("FAIL first_src2: got %h expected 1f", out_src2_tag_a); end
    checks++; if (rat_start_a !== 1'b1 || out_shot_id_a !== 3'd7) begin errors++; $display("FAIL first_shot: got start=%b id=%0d expected start=1 id=7", rat_start_a, out_shot_id_a); end
    checks++; if (rat_shot_in_a !== pack_map()) begin errors++; $display("FAIL identity_snap: got %h expected %h", rat_shot_in_a, pack_map()); end
  endtask

  task automatic test_forward();
    @(negedge clk);
    idle(); rat_shot_air = '0;
    ren_valid_a = 1; ren_dst_a = 3; ren_dst_we_a = 1; ren_new_tag_a = 8'd40;
    ren_valid_b = 0; ren_dst_b = 3; ren_dst_we_b = 1; ren_new_tag_b = 8'd99;
    ren_valid_c = 1; ren_src1_c = 3; ren_src2_c = 9;
    ren_valid_d = 1; ren_src1_d = 3; ren_dst_d = 3; ren_dst_we_d = 1; ren_new_tag_d = 8'd41;
    @(posedge clk); #1;
    m[3] = 8'd41;
    checks++; if (out_src1_tag_c !== 8'd40) begin errors++; $display("FAIL fwd_c_src1: got %h expected 28", out_src1_tag_c); end
    checks++; if (out_src2_tag_c !== 8'd9) begin errors++; $display("FAIL fwd_c_src2: got %h expected 09", out_src2_tag_c); end
    checks++; if (out_old_tag_d !== 8'd40 || out_src1_tag_d !== 8'd40) begin errors++; $display("FAIL fwd_d: got old=%h src1=%h expected 28 28", out_old_tag_d, out_src1_tag_d); end
    checks++; if (out_old_tag_a !== 8'd3) begin errors++; $display("FAIL fwd_a_old: got %h expected 03", out_old_tag_a); end
    checks++; if ({out_valid_d, out_valid_c, out_valid_b, out_valid_a} !== 4'b1101) begin errors++; $display("FAIL fwd_valid: got %b expected 1101", {out_valid_d, out_valid_c, out_valid_b, out_valid_a}); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    idle();
    ren_valid_a = 1; ren_src1_a = 3;
    @(posedge clk); #1;
    checks++; if (out_src1_tag_a !== 8'd41) begin errors++; $display("FAIL b2b_map3: got %h expected 29", out_src1_tag_a); end
  endtask

  task automatic test_branch_slots();
    @(negedge clk);
    idle();
    rat_shot_air = 32'h8501_8207;
    ren_valid_a = 1; ren_dst_a = 7; ren_dst_we_a = 1; ren_new_tag_a = 8'h70;
    ren_valid_b = 1; ren_dst_b = 8; ren_dst_we_b = 1; ren_new_tag_b = 8'h80; ren_branch_b = 1;
    ren_valid_c = 1; ren_dst_c = 9; ren_dst_we_c = 1; ren_new_tag_c = 8'h90; ren_src1_c = 8;
    ren_valid_d = 1; ren_dst_d = 8; ren_dst_we_d = 1; ren_new_tag_d = 8'h81; ren_branch_d = 1;
    m[7] = 8'h70; m[8] = 8'h80; exp_b = pack_map();
    m[9] = 8'h90; m[8] = 8'h81; exp_d = pack_map();
    #1;
    checks++; if (ren_stall !== 1'b0) begin errors++; $display("FAIL br_stall: got %b expected 0", ren_stall); end
    @(posedge clk); #1;
    checks++; if (out_shot_id_b !== 3'd2 || out_shot_id_d !== 3'd5) begin errors++; $display("FAIL br_ids: got b=%0d d=%0d expected 2 5", out_shot_id_b, out_shot_id_d); end
    checks++; if (rat_shot_in_b !== exp_b) begin errors++; $display("FAIL br_snap_b: got %h expected %h", rat_shot_in_b, exp_b); end
    checks++; if (rat_shot_in_d !== exp_d) begin errors++; $display("FAIL br_snap_d: got %h expected %h", rat_shot_in_d, exp_d); end
    checks++; if ({rat_start_d, rat_start_c, rat_start_b, rat_start_a} !== 4'b1010) begin errors++; $display("FAIL br_start: got %b expected 1010", {rat_start_d, rat_start_c, rat_start_b, rat_start_a}); end
    checks++; if (out_src1_tag_c !== 8'h80 || out_old_tag_d !== 8'h80) begin errors++; $display("FAIL br_fwd: got c=%h d_old=%h expected 80 80", out_src1_tag_c, out_old_tag_d); end
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    checks++; if ({rat_start_d, rat_start_c, rat_start_b, rat_start_a, out_valid_a} !== 5'b0) begin errors++; $display("FAIL br_pulse: got %b expected 0", {rat_start_d, rat_start_c, rat_start_b, rat_start_a, out_valid_a}); end
  endtask

  task automatic test_stall();
    @(negedge clk);
    idle();
    rat_shot_air = 32'h0000_8481;
    ren_valid_a = 1; ren_branch_a = 1; ren_dst_a = 10; ren_dst_we_a = 1; ren_new_tag_a = 8'hAA;
    ren_valid_b = 1; ren_branch_b = 1;
    ren_valid_c = 1; ren_branch_c = 1;
    #1;
    checks++; if (ren_stall !== 1'b1) begin errors++; $display("FAIL st_stall: got %b expected 1", ren_stall); end
    @(posedge clk); #1;
    checks++; if ({out_valid_c, out_valid_b, out_valid_a, rat_start_a, rat_start_b, rat_start_c} !== 6'b0) begin errors++; $display("FAIL st_noout: got %b expected 0", {out_valid_c, out_valid_b, out_valid_a, rat_start_a, rat_start_b, rat_start_c}); end
    @(negedge clk);
    rat_shot_air = 32'h0086_8481;
    #1;
    checks++; if (ren_stall !== 1'b0) begin errors++; $display("FAIL st_release: got %b expected 0", ren_stall); end
    @(posedge clk); #1;
    m[10] = 8'hAA;
    checks++; if ({out_valid_c, out_valid_b, out_valid_a} !== 3'b111) begin errors++; $display("FAIL st_valid: got %b expected 111", {out_valid_c, out_valid_b, out_valid_a}); end
    checks++; if ({out_shot_id_a, out_shot_id_b, out_shot_id_c} !== {3'd1, 3'd4, 3'd6}) begin errors++; $display("FAIL st_ids: got %0d %0d %0d expected 1 4 6", out_shot_id_a, out_shot_id_b, out_shot_id_c); end
    checks++; if (rat_shot_in_a !== pack_map() || rat_shot_in_c !== pack_map()) begin errors++; $display("FAIL st_snap: got a=%h c=%h expected %h", rat_shot_in_a, rat_shot_in_c, pack_map()); end
  endtask

  task automatic test_kill();
    @(negedge clk);
    idle();
    rat_shot_air = 32'h0000_0080;
    rob_kill_adderss = {32{8'h10}};
    rob_kill_start = 1;
    ren_valid_a = 1; ren_dst_a = 12; ren_dst_we_a = 1; ren_new_tag_a = 8'hCC;
    ren_valid_b = 1; ren_branch_b = 1;
    #1;
    checks++; if (ren_stall !== 1'b1) begin errors++; $display("FAIL kill_stall0: got %b expected 1", ren_stall); end
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) m[i] = 8'h10;
`ifdef RAT_R0_ZERO_EN
    m[0] = 8'h00;
`endif
    checks++; if ({out_valid_a, out_valid_b, rat_start_b} !== 3'b0) begin errors++; $display("FAIL kill_drop: got %b expected 0", {out_valid_a, out_valid_b, rat_start_b}); end
    @(negedge clk);
    idle();
    ren_valid_a = 1; ren_src1_a = 4; ren_src2_a = 12;
    #1;
    checks++; if (ren_stall !== 1'b1) begin errors++; $display("FAIL kill_stall1: got %b expected 1", ren_stall); end
    @(posedge clk); #1;
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL kill_restore_valid: got %b expected 0", out_valid_a); end
    @(negedge clk); #1;
    checks++; if (ren_stall !== 1'b0) begin errors++; $display("FAIL kill_run: got %b expected 0", ren_stall); end
    @(posedge clk); #1;
    checks++; if (out_valid_a !== 1'b1 || out_src1_tag_a !== m[4] || out_src2_tag_a !== m[12]) begin errors++; $display("FAIL kill_lookup: got v=%b %h %h expected 1 10 10", out_valid_a, out_src1_tag_a, out_src2_tag_a); end
  endtask

  task automatic test_reset_in_restore();
    @(negedge clk);
    idle();
    rob_kill_adderss = {32{8'h10}};
    rob_kill_start = 1;
    @(posedge clk);
    @(negedge clk);
    rob_kill_start = 0;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) m[i] = 8'(i);
    checks++; if (ren_stall !== 1'b0) begin errors++; $display("FAIL rr_state: got stall %b expected 0", ren_stall); end
    checks++; if (out_src1_tag_a !== 8'h00 || rat_shot_in_a !== '0 || out_valid_a !== 1'b0) begin errors++; $display("FAIL rr_outputs: got src1=%h v=%b expected 00 0", out_src1_tag_a, out_valid_a); end
    @(negedge clk);
    reset = 1'b1;
    ren_valid_a = 1; ren_src1_a = 6; ren_src2_a = 12;
    @(posedge clk); #1;
    checks++; if (out_valid_a !== 1'b1 || out_src1_tag_a !== 8'd6 || out_src2_tag_a !== 8'd12) begin errors++; $display("FAIL rr_identity: got v=%b %h %h expected 1 06 0c", out_valid_a, out_src1_tag_a, out_src2_tag_a); end
  endtask

  task automatic test_r0();
    logic [7:0] e0;
`ifdef RAT_R0_ZERO_EN
    e0 = 8'd0;
`else
    e0 = 8'd9;
`endif
    @(negedge clk);
    idle();
    ren_valid_a = 1; ren_dst_a = 0; ren_dst_we_a = 1; ren_new_tag_a = 8'd9;
    ren_valid_b = 1; ren_src1_b = 0;
    @(posedge clk); #1;
    m[0] = e0;
    checks++; if (out_src1_tag_b !== e0) begin errors++; $display("FAIL r0_fwd: got %h expected %h", out_src1_tag_b, e0); end
    checks++; if (out_old_tag_a !== 8'd0) begin errors++; $display("FAIL r0_old: got %h expected 00", out_old_tag_a); end
    @(negedge clk);
    idle();
    rat_shot_air = 32'h0000_0083;
    ren_valid_a = 1; ren_src1_a = 0; ren_branch_a = 1;
    @(posedge clk); #1;
    checks++; if (out_src1_tag_a !== e0 || out_shot_id_a !== 3'd3) begin errors++; $display("FAIL r0_map: got %h id=%0d expected %h id=3", out_src1_tag_a, out_shot_id_a, e0); end
    checks++; if (rat_shot_in_a !== pack_map()) begin errors++; $display("FAIL r0_snap: got %h expected %h", rat_shot_in_a, pack_map()); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_back_to_back();
    test_branch_slots();
    test_stall();
    test_kill();
    test_reset_in_restore();
    test_r0();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
